// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and rate helper for the configurable UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } rx_state_t;

    // System clocks per oversample tick; integer division, remainder is dropped.
    function automatic int clks_per_sample(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - generic wrap-around counter with synchronous clear
module Counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count
);

    // Count 0..last while enabled, returning to 0 after the terminal value.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == last) ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_sampler.sv
// rtl/rx_sampler.sv - rx synchronizer, oversample tick generator and 3-sample majority vote
module rx_sampler #(
    parameter int CLKS_PER_SAMPLE = 10,
    parameter int OVERSAMPLE      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          run,
    output logic                          rx_sync,
    output logic                          fall_edge,
    output logic                          tick,
    output logic                          vote_valid,
    output logic                          vote,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_count
);

    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    logic          sync_meta;
    logic          sync_prev;
    logic [CW-1:0] clk_count;
    logic          sample_early;
    logic          sample_mid;

    // Two-flop synchronizer plus one edge-detect register; all idle high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= rx;
            rx_sync   <= sync_meta;
            sync_prev <= rx_sync;
        end
    end

    assign fall_edge = sync_prev & ~rx_sync;

    Counter #(.WIDTH(CW)) u_clk_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (!run),
        .enable (run),
        .last   (CW'(CLKS_PER_SAMPLE - 1)),
        .count  (clk_count)
    );

    assign tick = run && (clk_count == CW'(CLKS_PER_SAMPLE - 1));

    Counter #(.WIDTH(SW)) u_sample_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (!run),
        .enable (tick),
        .last   (SW'(OVERSAMPLE - 1)),
        .count  (sample_count)
    );

    // Capture the two samples that precede the bit centre's resolving tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_early <= 1'b1;
            sample_mid   <= 1'b1;
        end else if (tick && (sample_count == SW'(M - 1))) begin
            sample_early <= rx_sync;
        end else if (tick && (sample_count == SW'(M))) begin
            sample_mid <= rx_sync;
        end
    end

    // Third sample is taken live at tick M+1, so the vote is ready on that tick.
    assign vote_valid = tick && (sample_count == SW'(M + 1));
    assign vote       = (sample_early & sample_mid) | (sample_early & rx_sync) | (sample_mid & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with valid/ready output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun
);

    localparam int      CPS      = clks_per_sample(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int      SW       = $clog2(OVERSAMPLE);
    localparam parity_t PAR_MODE = parity_t'(2'(PARITY));

    if (CPS < 2) begin : g_rate_check
        $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_cfg: illegal frame parameters");
    end

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  run;
    logic                  rx_sync;
    logic                  fall_edge;
    logic                  tick;
    logic                  vote_valid;
    logic                  vote;
    logic [SW-1:0]         sample_count;
    logic                  sample_wrap;
    logic [3:0]            bit_count;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bit;
    logic                  par_err_acc;
    logic                  frame_acc;
    logic                  last_data_bit;
    logic                  last_stop;
    logic                  frame_fe;
    logic                  frame_break;
    logic                  done;

    assign run = (state == S_START) || (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

    rx_sampler #(
        .CLKS_PER_SAMPLE (CPS),
        .OVERSAMPLE      (OVERSAMPLE)
    ) u_sampler (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .run          (run),
        .rx_sync      (rx_sync),
        .fall_edge    (fall_edge),
        .tick         (tick),
        .vote_valid   (vote_valid),
        .vote         (vote),
        .sample_count (sample_count)
    );

    assign sample_wrap   = tick && (sample_count == SW'(OVERSAMPLE - 1));
    assign last_data_bit = (bit_count == 4'(DATA_WIDTH - 1));
    assign last_stop     = (STOP_BITS == 1) || stop_idx;

    // Frame status as of the last stop-bit vote; frame_acc remembers an earlier bad stop bit.
    assign frame_fe    = frame_acc | ~vote;
    assign frame_break = (shift_reg == '0) && ((PAR_MODE == NONE) || !par_bit) && !vote &&
                         ((STOP_BITS == 1) || frame_acc);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; completion fires at the last stop vote so the line can resync early.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_edge) state_next = S_START;
            end
            S_START: begin
                if (vote_valid && vote) state_next = S_IDLE;
                else if (sample_wrap)   state_next = S_DATA;
            end
            S_DATA: begin
                if (sample_wrap && last_data_bit) state_next = (PAR_MODE != NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (sample_wrap) state_next = S_STOP;
            end
            S_STOP: begin
                if (vote_valid && last_stop) begin
                    done       = 1'b1;
                    state_next = frame_break ? S_BREAK_WAIT : S_IDLE;
                end
            end
            S_BREAK_WAIT: begin
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift register, bit/stop indices and per-frame error accumulators.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg   <= '0;
            bit_count   <= '0;
            stop_idx    <= 1'b0;
            par_bit     <= 1'b0;
            par_err_acc <= 1'b0;
            frame_acc   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_count   <= '0;
                    stop_idx    <= 1'b0;
                    par_bit     <= 1'b0;
                    par_err_acc <= 1'b0;
                    frame_acc   <= 1'b0;
                end
                S_DATA: begin
                    if (vote_valid)  shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
                    if (sample_wrap) bit_count <= bit_count + 4'd1;
                end
                S_PARITY: begin
                    if (vote_valid) begin
                        par_bit     <= vote;
                        par_err_acc <= (PAR_MODE == ODD) ? ~(^shift_reg ^ vote) : (^shift_reg ^ vote);
                    end
                end
                S_STOP: begin
                    if (vote_valid && !vote) frame_acc <= 1'b1;
                    if (sample_wrap)         stop_idx  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun on a blocked completion.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg;
                    parity_err <= par_err_acc;
                    frame_err  <= frame_fe;
                    break_det  <= frame_break;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1 and 8E2 instances)
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rdy_a, rx_b, rdy_b;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_pe, a_fe, a_bk, a_ov;
    logic       b_valid, b_pe, b_fe, b_bk, b_ov;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] got_a[$];
    logic [10:0] got_b[$];
    int rd_a = 0;
    int rd_b = 0;
    int vcyc_a = 0;
    int ovr_a  = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
        .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
    ) u_a (
        .clock(clk), .reset(rst_n), .rx(rx_a), .rx_ready(rdy_a),
        .rx_data(a_data), .rx_valid(a_valid), .parity_err(a_pe),
        .frame_err(a_fe), .break_det(a_bk), .overrun(a_ov)
    );

    uart_rx_cfg #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
        .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)
    ) u_b (
        .clock(clk), .reset(rst_n), .rx(rx_b), .rx_ready(rdy_b),
        .rx_data(b_data), .rx_valid(b_valid), .parity_err(b_pe),
        .frame_err(b_fe), .break_det(b_bk), .overrun(b_ov)
    );

    // Consumer side: record every accepted frame and count valid/overrun cycles.
    always @(negedge clk) begin
        if (a_valid && rdy_a) got_a.push_back({a_bk, a_fe, a_pe, a_data});
        if (b_valid && rdy_b) got_b.push_back({b_bk, b_fe, b_pe, b_data});
        if (a_valid) vcyc_a++;
        if (a_ov)    ovr_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: frame result from the bits put on the wire.
    function automatic logic [10:0] model(input logic [7:0] d, input logic pbit, input int pmode,
                                          input logic [1:0] stops, input int nstops);
        int   ones;
        logic pe, fe, bk;
        ones = $countones(d) + ((pmode != 0) ? int'(pbit) : 0);
        pe = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
        fe = !stops[0] || (nstops == 2 && !stops[1]);
        bk = (d == 8'h00) && (pmode == 0 || !pbit) && !stops[0] && (nstops == 1 || !stops[1]);
        return {bk, fe, pe, d};
    endfunction

    task automatic drive(input int line, input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (line == 0) rx_a = v;
            else           rx_b = v;
        end
    endtask

    task automatic send(input int line, input logic [7:0] d, input bit has_par, input logic pbit,
                        input int nstops, input logic [1:0] stops, input int glitch_bit);
        drive(line, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(line, d[i], 85);
                drive(line, ~d[i], 10);
                drive(line, d[i], 65);
            end else begin
                drive(line, d[i], BIT_CLKS);
            end
        end
        if (has_par) drive(line, pbit, BIT_CLKS);
        for (int s = 0; s < nstops; s++) drive(line, stops[s], BIT_CLKS);
        drive(line, 1'b1, BIT_CLKS);
    endtask

    task automatic expect_frame(input int line, input string tag, input logic [10:0] exp);
        int          avail;
        logic [10:0] w;
        avail = (line == 0) ? (got_a.size() - rd_a) : (got_b.size() - rd_b);
        check({tag, "_count"}, avail, 1);
        if (avail > 0) begin
            if (line == 0) begin w = got_a[rd_a]; rd_a++; end
            else           begin w = got_b[rd_b]; rd_b++; end
            check(tag, w, exp);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        int         base;

        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", {a_data, a_valid, a_pe, a_fe, a_bk, a_ov}, 0);
        check("reset_b", {b_data, b_valid, b_pe, b_fe, b_bk, b_ov}, 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * BIT_CLKS);

        base = vcyc_a;
        send(0, 8'hA5, 0, 1'b0, 1, 2'b11, 0);
        expect_frame(0, "glitch_a5", model(8'hA5, 1'b0, 0, 2'b11, 1));
        check("glitch_valid_cycles", vcyc_a - base, 1);

        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send(0, d, 0, 1'b0, 1, 2'b11, -1);
            expect_frame(0, "rand_8n1", model(d, 1'b0, 0, 2'b11, 1));
        end

        send(0, 8'h3C, 0, 1'b0, 1, 2'b00, -1);
        expect_frame(0, "stop_zero", model(8'h3C, 1'b0, 0, 2'b00, 1));

        drive(0, 1'b0, 20 * BIT_CLKS);
        expect_frame(0, "break", model(8'h00, 1'b0, 0, 2'b00, 1));
        check("break_no_extra", got_a.size() - rd_a, 0);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("break_release_quiet", got_a.size() - rd_a, 0);
        d = 8'($urandom);
        send(0, d, 0, 1'b0, 1, 2'b11, -1);
        expect_frame(0, "after_break", model(d, 1'b0, 0, 2'b11, 1));

        drive(0, 1'b0, 30);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("short_low_none", got_a.size() - rd_a, 0);
        send(0, 8'h5A, 0, 1'b0, 1, 2'b11, -1);
        expect_frame(0, "after_short", model(8'h5A, 1'b0, 0, 2'b11, 1));

        rdy_a = 1'b0;
        base  = ovr_a;
        send(0, 8'h11, 0, 1'b0, 1, 2'b11, -1);
        send(0, 8'h22, 0, 1'b0, 1, 2'b11, -1);
        check("ovr_valid_held", a_valid, 1);
        check("ovr_data_kept", a_data, 8'h11);
        check("ovr_pulse_cycles", ovr_a - base, 1);
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        check("ovr_handshake_drop", a_valid, 0);
        rd_a = got_a.size();

        send(1, 8'h07, 1, 1'b0, 2, 2'b11, -1);
        expect_frame(1, "even_par_bad", model(8'h07, 1'b0, 2, 2'b11, 2));
        send(1, 8'h07, 1, 1'b1, 2, 2'b11, -1);
        expect_frame(1, "even_par_good", model(8'h07, 1'b1, 2, 2'b11, 2));
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            send(1, d, 1, p, 2, 2'b11, -1);
            expect_frame(1, "rand_8e2", model(d, p, 2, 2'b11, 2));
        end
        d = 8'($urandom);
        send(1, d, 1, ^d, 2, 2'b01, -1);
        expect_frame(1, "second_stop_zero", model(d, ^d, 2, 2'b01, 2));

        rdy_b = 1'b0;
        d = 8'($urandom) | 8'h01;
        send(1, d, 1, ^d, 2, 2'b11, -1);
        check("held_b_valid", b_valid, 1);
        d = 8'($urandom);
        drive(1, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(1, d[i], BIT_CLKS);
        drive(1, 1'b1, 80);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_mid_b", {b_data, b_valid, b_pe, b_fe, b_bk, b_ov}, 0);
        drive(1, 1'b1, 3 * BIT_CLKS);
        rdy_b = 1'b1;
        rd_b  = got_b.size();
        send(1, 8'hC3, 1, 1'b0, 2, 2'b11, -1);
        expect_frame(1, "after_reset_c3", model(8'hC3, 1'b0, 2, 2'b11, 2));
        check("after_reset_no_extra", got_b.size() - rd_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, oversampling UART receiver. Adds configurable parity, one or two stop bits, 3-sample majority voting, framing/parity/break detection, and a valid/ready output with overrun reporting. Sits between the asynchronous `rx` pad and any byte-stream consumer (FIFO or command parser) in the same clock domain.

## Interface
- `CLK_FREQ`, 100_000_000: system clock in Hz.
- `BAUD_RATE`, 115200: line rate.
- `DATA_WIDTH`, 8: data bits per frame. Legal range 5–9.
- `OVERSAMPLE`, 16: sample ticks per bit. Even, ≥ 8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clock` in 1: single clock. Every flop is in this domain.
- `reset` in 1: synchronous, active-low.
- `rx` in 1: asynchronous serial line. Idles high.
- `rx_ready` in 1: consumer accepts the held frame.
- `rx_data` out DATA_WIDTH: received word, LSB-first assembled.
- `rx_valid` out 1: `rx_data` and the error flags are held and valid.
- `parity_err` out 1: the parity bit mismatched. Qualified by `rx_valid`.
- `frame_err` out 1: a stop bit sampled 0. Qualified by `rx_valid`.
- `break_det` out 1: all data bits, parity and stop bits were 0. Qualified by `rx_valid`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- `CLKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer division. Elaboration error if the result is < 2.
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator: `clk_count` counts 0..CLKS_PER_SAMPLE-1. `tick` fires at the terminal count. The counter is held at 0 in IDLE and BREAK_WAIT.
- `sample_count` counts ticks 0..OVERSAMPLE-1 and wraps.
- Vote: the bit value is the majority of the samples at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The vote is resolved at tick M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on a synchronized 1→0 edge, go to START and clear the counters.
  - START: if the vote is 1 (glitch), return to IDLE. Otherwise go to DATA on the `sample_count` wrap.
  - DATA: shift the vote into `bit_count` position, LSB first. After DATA_WIDTH bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: store the vote and compare it against the XOR of the data bits. Odd mode requires an odd total count of ones; even mode requires an even total. Go to STOP.
  - STOP: vote each stop bit. A 0 on any stop bit sets frame error.
    - The frame completes at the vote of the last stop bit, not at the end of the bit, so the receiver can resynchronize early.
    - If it is a break, go to BREAK_WAIT; otherwise go to IDLE.
  - BREAK_WAIT: stay until the synchronized `rx` is 1, then go to IDLE. No start detection while in this state.
- Output register:
  - On completion, load `rx_data`, the three flags and `rx_valid`=1.
  - Hold all of them while `rx_valid && !rx_ready`.
  - Clear `rx_valid` the cycle after a handshake.
- Completion while `rx_valid=1` and `rx_ready=0`: the new frame is discarded, the old one is kept, and `overrun` pulses for 1 cycle.
- Completion in the same cycle as a handshake: the new frame is loaded, `rx_valid` stays 1, and there is no overrun.
- Reset mid-frame: the FSM returns to IDLE and the partial shift register is discarded.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `overrun`=0. FSM in IDLE, synchronizer flops at 1.
- Start detect latency: a falling edge on `rx` enters START 3 clocks later (2 synchronizer flops + 1 edge register).
- Frame latency: `rx_valid` rises 1 clock after the last-stop-bit vote. That is roughly 3 + ((1+DATA_WIDTH+P+STOP_BITS-1)·OVERSAMPLE + M+2)·CLKS_PER_SAMPLE clocks after the start edge, where P = 1 if parity is enabled, else 0.
- `rx_valid` is never deasserted without a handshake, except by reset.

## Structure
- `uart_pkg`:
  - `parity_t` enum: NONE, ODD, EVEN.
  - `rx_state_t` enum.
  - A function that computes CLKS_PER_SAMPLE.
- Sub-module `rx_sampler`: synchronizer, tick generator, sample counter and majority vote. Outputs are `rx_sync`, `fall_edge`, `tick`, `vote_valid` and `vote`.
- Counters reuse the existing `Counter` module.
- The FSM, shift register and output register live in `uart_rx_cfg`.

## Test plan
All scenarios use CLK_FREQ=1_600_000 and BAUD_RATE=10_000. With OVERSAMPLE=16 this gives 10 clocks per sample and 160 clocks per bit.
- 8N1, frame 0xA5 with `rx_ready`=1, plus a 1-sample low glitch at tick M of bit 0 → one-cycle `rx_valid`, `rx_data`=0xA5, all flags 0. The vote corrects the glitch.
- PARITY=2 (even), data 0x07 sent with parity bit 0 → `rx_data`=0x07, `parity_err`=1. The same frame with parity bit 1 gives `parity_err`=0.
- 0x3C with stop bit 0 → `frame_err`=1. Then hold `rx` low for 20 bit times → `break_det`=1 and `frame_err`=1, and no new frame until `rx` returns high.
- `rx` low for 30 clocks only → no `rx_valid`, FSM back in IDLE. A following 0x5A is received correctly.
- Frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses 1 cycle. Raising `rx_ready` completes the handshake and `rx_valid` drops.
- `reset`=0 for 1 cycle at data bit 4 → all outputs 0 the next cycle. A subsequent clean 0xC3 with STOP_BITS=2 is received with no flags set.
